// File: rtl/dvfs_sequencer_pkg.sv
// Shared definitions for the DVFS sequencer: FSM encoding, reset codes and
// the voltage-dependent frequency ceiling.
package dvfs_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_V_UP   = 2'd1,
    ST_F_CHG  = 2'd2,
    ST_V_DOWN = 2'd3
  } dvfs_state_t;

  localparam logic [1:0] V_RST = 2'b01;
  localparam logic [2:0] F_RST = 3'b010;

  // Highest frequency code a voltage code can sustain: 2*V+1.
  function automatic logic [2:0] fmax(input logic [1:0] v);
    return {v, 1'b1};
  endfunction

  function automatic logic [2:0] clamp_f(input logic [1:0] v, input logic [2:0] f);
    return (f > fmax(v)) ? fmax(v) : f;
  endfunction

endpackage

// File: rtl/dvfs_sequencer_if.sv
// Request/status bundle between the power manager and the DVFS sequencer.
interface dvfs_sequencer_if;

  logic       power_save;
  logic [1:0] vcore1_req, vcore2_req, vmem_req;
  logic [2:0] fcore1_req, fcore2_req, fmem_req;
  logic [1:0] vcore1_out, vcore2_out, vmem_out;
  logic [2:0] fcore1_out, fcore2_out, fmem_out;
  logic [2:0] clk_en;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] clamp;
  logic       ps_ack;

  modport master (
    output power_save, vcore1_req, vcore2_req, vmem_req,
           fcore1_req, fcore2_req, fmem_req,
    input  vcore1_out, vcore2_out, vmem_out, fcore1_out, fcore2_out, fmem_out,
           clk_en, busy, done, clamp, ps_ack
  );

  modport slave (
    input  power_save, vcore1_req, vcore2_req, vmem_req,
           fcore1_req, fcore2_req, fmem_req,
    output vcore1_out, vcore2_out, vmem_out, fcore1_out, fcore2_out, fmem_out,
           clk_en, busy, done, clamp, ps_ack
  );

endinterface

// File: rtl/dvfs_domain_seq.sv
// Single-domain voltage/frequency sequencer: raises voltage before frequency,
// lowers frequency before voltage, and gates the domain clock while the PLL relocks.
module dvfs_domain_seq
  import dvfs_sequencer_pkg::*;
#(
  parameter int unsigned VSTEP_CYC = 8,
  parameter int unsigned FLOCK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] v_req,
  input  logic [2:0] f_req,
  output logic [1:0] v_out,
  output logic [2:0] f_out,
  output logic       clk_en,
  output logic       busy,
  output logic       done,
  output logic       clamp
);

  // A zero parameter behaves as a one-cycle wait.
  localparam logic [7:0] VLOAD = (VSTEP_CYC == 0) ? 8'd0 : 8'(VSTEP_CYC - 1);
  localparam logic [7:0] FLOAD = (FLOCK_CYC == 0) ? 8'd0 : 8'(FLOCK_CYC - 1);

  dvfs_state_t state, state_nxt;
  logic [1:0]  v_tgt, v_tgt_nxt, v_nxt;
  logic [2:0]  f_tgt, f_tgt_nxt, f_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        clamp_lat, clamp_lat_nxt;
  logic        clk_en_nxt, busy_nxt, done_nxt, clamp_nxt;
  logic [2:0]  f_req_cl;

  assign f_req_cl = clamp_f(v_req, f_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      v_out     <= V_RST;
      f_out     <= F_RST;
      v_tgt     <= V_RST;
      f_tgt     <= F_RST;
      cnt       <= 8'd0;
      clamp_lat <= 1'b0;
      clk_en    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      clamp     <= 1'b0;
    end else begin
      state     <= state_nxt;
      v_out     <= v_nxt;
      f_out     <= f_nxt;
      v_tgt     <= v_tgt_nxt;
      f_tgt     <= f_tgt_nxt;
      cnt       <= cnt_nxt;
      clamp_lat <= clamp_lat_nxt;
      clk_en    <= clk_en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      clamp     <= clamp_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    v_nxt         = v_out;
    f_nxt         = f_out;
    v_tgt_nxt     = v_tgt;
    f_tgt_nxt     = f_tgt;
    cnt_nxt       = cnt;
    clamp_lat_nxt = clamp_lat;
    clk_en_nxt    = clk_en;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    clamp_nxt     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if ((v_req != v_out) || (f_req_cl != f_out)) begin
          v_tgt_nxt     = v_req;
          f_tgt_nxt     = f_req_cl;
          clamp_lat_nxt = (f_req > fmax(v_req));
          busy_nxt      = 1'b1;
          cnt_nxt       = 8'd0;
          if (v_req > v_out)
            state_nxt = ST_V_UP;
          else if ((v_req < v_out) && (f_req_cl == f_out))
            state_nxt = ST_V_DOWN;
          else
            state_nxt = ST_F_CHG;
        end
      end

      ST_V_UP: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (v_out != v_tgt) begin
          v_nxt   = 2'(v_out + 2'd1);
          cnt_nxt = VLOAD;
        end else if (f_out != f_tgt) begin
          state_nxt  = ST_F_CHG;
          f_nxt      = f_tgt;
          clk_en_nxt = 1'b0;
          cnt_nxt    = FLOAD;
        end else begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          clamp_nxt = clamp_lat;
        end
      end

      ST_F_CHG: begin
        // clk_en still high means the frequency switch has not been applied yet.
        if (clk_en) begin
          f_nxt      = f_tgt;
          clk_en_nxt = 1'b0;
          cnt_nxt    = FLOAD;
        end else if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          clk_en_nxt = 1'b1;
          if (v_out != v_tgt) begin
            state_nxt = ST_V_DOWN;
            v_nxt     = 2'(v_out - 2'd1);
            cnt_nxt   = VLOAD;
          end else begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            clamp_nxt = clamp_lat;
          end
        end
      end

      ST_V_DOWN: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (v_out != v_tgt) begin
          v_nxt   = 2'(v_out - 2'd1);
          cnt_nxt = VLOAD;
        end else begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          clamp_nxt = clamp_lat;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/dvfs_sequencer.sv
// Three-domain DVFS sequencer (core1, core2, mem) with power-save acknowledge.
module dvfs_sequencer
  import dvfs_sequencer_pkg::*;
#(
  parameter int unsigned VSTEP_CYC = 8,
  parameter int unsigned FLOCK_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dvfs_sequencer_if.slave   bus
);

  logic [1:0] v_out_w [3];
  logic [2:0] f_out_w [3];
  logic [2:0] clk_en_w, busy_w, done_w, clamp_w;
  logic       ps_ack_r;

  dvfs_domain_seq #(.VSTEP_CYC(VSTEP_CYC), .FLOCK_CYC(FLOCK_CYC)) u_core1 (
    .clk(clk), .rst_n(rst_n), .v_req(bus.vcore1_req), .f_req(bus.fcore1_req),
    .v_out(v_out_w[0]), .f_out(f_out_w[0]), .clk_en(clk_en_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .clamp(clamp_w[0])
  );

  dvfs_domain_seq #(.VSTEP_CYC(VSTEP_CYC), .FLOCK_CYC(FLOCK_CYC)) u_core2 (
    .clk(clk), .rst_n(rst_n), .v_req(bus.vcore2_req), .f_req(bus.fcore2_req),
    .v_out(v_out_w[1]), .f_out(f_out_w[1]), .clk_en(clk_en_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .clamp(clamp_w[1])
  );

  dvfs_domain_seq #(.VSTEP_CYC(VSTEP_CYC), .FLOCK_CYC(FLOCK_CYC)) u_mem (
    .clk(clk), .rst_n(rst_n), .v_req(bus.vmem_req), .f_req(bus.fmem_req),
    .v_out(v_out_w[2]), .f_out(f_out_w[2]), .clk_en(clk_en_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .clamp(clamp_w[2])
  );

  // Acknowledge only once every domain has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_ack_r <= 1'b0;
    else        ps_ack_r <= bus.power_save && (busy_w == 3'b000);
  end

  assign bus.vcore1_out = v_out_w[0];
  assign bus.vcore2_out = v_out_w[1];
  assign bus.vmem_out   = v_out_w[2];
  assign bus.fcore1_out = f_out_w[0];
  assign bus.fcore2_out = f_out_w[1];
  assign bus.fmem_out   = f_out_w[2];
  assign bus.clk_en     = clk_en_w;
  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.clamp      = clamp_w;
  assign bus.ps_ack     = ps_ack_r;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Directed bench for dvfs_sequencer: reset, raise, lower, clamp, busy-ignore,
// mid-sequence reset and power-save handshake.
module tb_dvfs_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dvfs_sequencer_if bus ();

  dvfs_sequencer #(.VSTEP_CYC(8), .FLOCK_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_v1"}, 8'(bus.vcore1_out), 8'h1);
    chk({tag, "_v2"}, 8'(bus.vcore2_out), 8'h1);
    chk({tag, "_vm"}, 8'(bus.vmem_out), 8'h1);
    chk({tag, "_f1"}, 8'(bus.fcore1_out), 8'h2);
    chk({tag, "_f2"}, 8'(bus.fcore2_out), 8'h2);
    chk({tag, "_fm"}, 8'(bus.fmem_out), 8'h2);
    chk({tag, "_clken"}, 8'(bus.clk_en), 8'h7);
    chk({tag, "_busy"}, 8'(bus.busy), 8'h0);
    chk({tag, "_done"}, 8'(bus.done), 8'h0);
    chk({tag, "_clamp"}, 8'(bus.clamp), 8'h0);
    chk({tag, "_psack"}, 8'(bus.ps_ack), 8'h0);
  endtask

  task automatic set_reset_reqs();
    bus.vcore1_req = 2'b01; bus.vcore2_req = 2'b01; bus.vmem_req = 2'b01;
    bus.fcore1_req = 3'b010; bus.fcore2_req = 3'b010; bus.fmem_req = 3'b010;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.power_save = 1'b0;
    set_reset_reqs();

    // Reset and 50 quiet cycles after release
    #12;
    chk_reset_vals("in_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      chk("idle_done", 8'(bus.done), 8'h0);
      chk("idle_busy", 8'(bus.busy), 8'h0);
    end
    chk_reset_vals("post_rst");

    // Core1 raise: V 01->11, F 010->111
    bus.vcore1_req = 2'b11; bus.fcore1_req = 3'b111;
    cyc(1);
    chk("up_busy", 8'(bus.busy), 8'h1);
    chk("up_v_d", 8'(bus.vcore1_out), 8'h1);
    cyc(1);
    chk("up_v_e1", 8'(bus.vcore1_out), 8'h2);
    cyc(7);
    chk("up_v_e8", 8'(bus.vcore1_out), 8'h2);
    cyc(1);
    chk("up_v_e9", 8'(bus.vcore1_out), 8'h3);
    chk("up_f_e9", 8'(bus.fcore1_out), 8'h2);
    cyc(8);
    chk("up_f_e17", 8'(bus.fcore1_out), 8'h7);
    chk("up_clken_e17", 8'(bus.clk_en), 8'h6);
    cyc(3);
    chk("up_clken_e20", 8'(bus.clk_en), 8'h6);
    chk("up_done_e20", 8'(bus.done), 8'h0);
    cyc(1);
    chk("up_done_e21", 8'(bus.done), 8'h1);
    chk("up_clamp_e21", 8'(bus.clamp), 8'h0);
    chk("up_busy_e21", 8'(bus.busy), 8'h0);
    chk("up_clken_e21", 8'(bus.clk_en), 8'h7);
    cyc(1);
    chk("up_done_e22", 8'(bus.done), 8'h0);
    chk("up_busy_e22", 8'(bus.busy), 8'h0);

    // Mem lower: V 01->00, F 010->001
    bus.vmem_req = 2'b00; bus.fmem_req = 3'b001;
    cyc(1);
    chk("dn_busy", 8'(bus.busy), 8'h4);
    cyc(1);
    chk("dn_f_e1", 8'(bus.fmem_out), 8'h1);
    chk("dn_clken_e1", 8'(bus.clk_en), 8'h3);
    chk("dn_v_e1", 8'(bus.vmem_out), 8'h1);
    cyc(3);
    chk("dn_clken_e4", 8'(bus.clk_en), 8'h3);
    cyc(1);
    chk("dn_clken_e5", 8'(bus.clk_en), 8'h7);
    chk("dn_v_e5", 8'(bus.vmem_out), 8'h0);
    cyc(7);
    chk("dn_done_e12", 8'(bus.done), 8'h0);
    chk("dn_busy_e12", 8'(bus.busy), 8'h4);
    cyc(1);
    chk("dn_done_e13", 8'(bus.done), 8'h4);
    chk("dn_clamp_e13", 8'(bus.clamp), 8'h0);
    chk("dn_busy_e13", 8'(bus.busy), 8'h0);

    // Core2 clamp: V 01 with F 111 requested -> F 011
    bus.vcore2_req = 2'b01; bus.fcore2_req = 3'b111;
    cyc(1);
    chk("cl_busy", 8'(bus.busy), 8'h2);
    cyc(1);
    chk("cl_f_e1", 8'(bus.fcore2_out), 8'h3);
    chk("cl_clken_e1", 8'(bus.clk_en), 8'h5);
    cyc(3);
    chk("cl_done_e4", 8'(bus.done), 8'h0);
    cyc(1);
    chk("cl_done_e5", 8'(bus.done), 8'h2);
    chk("cl_clamp_e5", 8'(bus.clamp), 8'h2);
    chk("cl_clken_e5", 8'(bus.clk_en), 8'h7);
    cyc(1);
    chk("cl_done_e6", 8'(bus.done), 8'h0);
    chk("cl_clamp_e6", 8'(bus.clamp), 8'h0);
    cyc(3);
    chk("cl_no_retrig", 8'(bus.busy), 8'h0);
    chk("cl_f_hold", 8'(bus.fcore2_out), 8'h3);

    // Core1 request changed while busy: 11/111 -> 10/101, then 01/011 mid-way
    bus.vcore1_req = 2'b10; bus.fcore1_req = 3'b101;
    cyc(1);
    chk("mo_busy", 8'(bus.busy), 8'h1);
    cyc(2);
    bus.vcore1_req = 2'b01; bus.fcore1_req = 3'b011;
    cyc(3);
    chk("mo_v_e5", 8'(bus.vcore1_out), 8'h2);
    chk("mo_f_e5", 8'(bus.fcore1_out), 8'h5);
    cyc(8);
    chk("mo_done_e13", 8'(bus.done), 8'h1);
    chk("mo_v_e13", 8'(bus.vcore1_out), 8'h2);
    chk("mo_f_e13", 8'(bus.fcore1_out), 8'h5);
    cyc(1);
    chk("mo_rebusy_e14", 8'(bus.busy), 8'h1);
    chk("mo_redone_e14", 8'(bus.done), 8'h0);
    cyc(13);
    chk("mo2_done", 8'(bus.done), 8'h1);
    chk("mo2_v", 8'(bus.vcore1_out), 8'h1);
    chk("mo2_f", 8'(bus.fcore1_out), 8'h3);

    // Reset asserted mid-V_UP on core1
    cyc(1);
    bus.vcore1_req = 2'b11; bus.fcore1_req = 3'b011;
    cyc(1);
    chk("rm_busy", 8'(bus.busy), 8'h1);
    cyc(1);
    chk("rm_v_e1", 8'(bus.vcore1_out), 8'h2);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    set_reset_reqs();
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("rm_nodone", 8'(bus.done), 8'h0);
      chk("rm_nobusy", 8'(bus.busy), 8'h0);
    end

    // Power save while core1 is busy
    bus.vcore1_req = 2'b10;
    cyc(1);
    chk("ps_busy", 8'(bus.busy), 8'h1);
    bus.power_save = 1'b1;
    cyc(1);
    chk("ps_ack_e1", 8'(bus.ps_ack), 8'h0);
    cyc(7);
    chk("ps_ack_e8", 8'(bus.ps_ack), 8'h0);
    cyc(1);
    chk("ps_done_e9", 8'(bus.done), 8'h1);
    chk("ps_ack_e9", 8'(bus.ps_ack), 8'h0);
    cyc(1);
    chk("ps_ack_e10", 8'(bus.ps_ack), 8'h1);
    bus.power_save = 1'b0;
    cyc(1);
    chk("ps_ack_off", 8'(bus.ps_ack), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvfs_sequencer.md
DVFS_SEQUENCER -- requirements
Module: dvfs_sequencer

Interface
REQ-001 Parameter VSTEP_CYC, default 8: settle cycles after each one-code voltage step.
REQ-002 Parameter FLOCK_CYC, default 4: cycles the domain clock is gated after a frequency change.
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 power_save  in  1  power-save indicator from the power manager.
REQ-006 vcore1_req, vcore2_req, vmem_req  in  2 each  requested voltage codes.
REQ-007 fcore1_req, fcore2_req, fmem_req  in  3 each  requested frequency codes.
REQ-008 vcore1_out, vcore2_out, vmem_out  out  2 each  applied voltage code to the regulator.
REQ-009 fcore1_out, fcore2_out, fmem_out  out  3 each  applied frequency code to the clock generator.
REQ-010 clk_en  out  3  per-domain clock enable; bit0=core1, bit1=core2, bit2=mem.
REQ-011 busy  out  3  per-domain sequence in progress.
REQ-012 done  out  3  per-domain one-cycle completion pulse.
REQ-013 clamp  out  3  per-domain pulse, coincident with done, when the requested frequency was clamped.
REQ-014 ps_ack  out  1  power-save acknowledge, registered.

Function
REQ-015 Each domain SHALL run an independent FSM: IDLE, V_UP, F_CHG, V_DOWN.
REQ-016 In IDLE, when the requested V or the clamped requested F differs from the applied value, the FSM SHALL latch the targets and set busy on the next edge.
REQ-017 Clamp rule: fmax(V) = 2*V+1; a requested F greater than fmax(target V) SHALL be latched as fmax, and clamp SHALL pulse with done.
REQ-018 Ordering: target V > applied V -> V_UP, then F_CHG if F differs. Target V < applied V -> F_CHG if F differs, then V_DOWN. Equal V -> F_CHG only.
REQ-019 V_UP/V_DOWN: on the entry edge, v_out SHALL move one code toward the target, then hold for VSTEP_CYC cycles; steps repeat until v_out equals the target and its settle has expired.
REQ-020 F_CHG: on the entry edge, f_out SHALL take the target and clk_en SHALL drop; clk_en SHALL stay low for exactly FLOCK_CYC cycles.
REQ-021 Completion: busy SHALL drop and done SHALL pulse on the same edge that returns the FSM to IDLE.
REQ-022 Latency from the request-detect edge to done SHALL be 1 + Nsteps*VSTEP_CYC + (F changed ? FLOCK_CYC : 0) cycles.
REQ-023 Request changes while busy SHALL be ignored; they are re-evaluated in the first IDLE cycle after done.
REQ-024 At no time SHALL f_out exceed fmax(v_out).
REQ-025 ps_ack SHALL be 1 the cycle after power_save=1 with all busy bits 0; otherwise 0.
REQ-026 Settle and lock counters SHALL be 8 bits; parameter values of 0 SHALL behave as 1.

Reset
REQ-027 Asynchronous reset SHALL, in all domains, force:
- FSM to IDLE;
- v_out=2'b01 and f_out=3'b010;
- clk_en=3'b111;
- busy, done, clamp and ps_ack to 0;
- counters to 0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately to the REQ-027 values, with no done pulse.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state encoding;
- the reset codes V_RST=2'b01 and F_RST=3'b010;
- the fmax function.
REQ-030 One sub-module, dvfs_domain_seq, SHALL implement a single domain; the top SHALL instantiate it three times and add the ps_ack logic.

Verification
REQ-031 Post-reset: release reset with requests at 01/010 -> all outputs at reset codes, busy=0, no done for 50 cycles.
REQ-032 Core1 raise: V 01->11, F 010->111 -> v_out steps to 10 then 11 at 8-cycle spacing. Then f_out=111 with clk_en[0] low 4 cycles. done at 1+16+4=21 cycles; clamp=0.
REQ-033 Mem lower: V 01->00, F 010->001 -> f_out=001 first with clk_en[2] low 4 cycles, then v_out=00. done at 1+4+8=13 cycles.
REQ-034 Clamp: core2 V 01 with F 111 requested -> f_out=011 (fmax(1)=3); clamp and done pulse together.
REQ-035 Mid-operation:
- Change the request while busy -> ignored until done, then a new sequence starts.
- Assert rst_n low mid-V_UP -> immediate reset values, no done.
REQ-036 Power save: power_save=1 while any domain is busy -> ps_ack=0; ps_ack goes to 1 one cycle after the last done.
